fp_hs_initiator: RTL and testbench

// - Initiator for the single-precision FP unit's stb/ack operand/result handshake.
// - Accepts one operand pair from the EXU over a valid/ready request port.
// - Drives operand A, then operand B, to the FP responder.
// - Collects result Z and returns it, with its tag, on a valid/ready response port.
// - Supports flush of an in-flight operation and a stall watchdog.

---
 rtl/fp_hs_initiator.sv | 174 +++++++++++++++++
 tb/tb_fp_hs_initiator.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_hs_initiator.sv
// fp_hs_initiator: accepts one operand pair from the EXU, hands A then B to the
// FP responder over stb/ack channels, collects result Z and returns it with its
// tag on a valid/ready response port. Supports flush and a per-phase watchdog.
//
// Ports:
//   clk, rst_l                     clock, asynchronous active-low reset
//   req_valid/req_ready/req_a/req_b/req_tag      EXU request port
//   resp_valid/resp_ready/resp_data/resp_tag     EXU response port
//   flush                          discard current/pending operation
//   output_a/output_a_stb/output_a_ack           operand A channel to responder
//   output_b/output_b_stb/output_b_ack           operand B channel to responder
//   input_z/input_z_stb/input_z_ack              result channel from responder
//   busy                           an operation is in flight
//   err_timeout                    sticky watchdog flag
module fp_hs_initiator #(
    parameter  int unsigned TAG_W   = 4,
    parameter  int unsigned TIMEOUT = 255,
    localparam int unsigned DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic [TAG_W-1:0]  resp_tag,
    input  logic              flush,
    output logic [DATA_W-1:0] output_a,
    output logic              output_a_stb,
    input  logic              output_a_ack,
    output logic [DATA_W-1:0] output_b,
    output logic              output_b_stb,
    input  logic              output_b_ack,
    input  logic [DATA_W-1:0] input_z,
    input  logic              input_z_stb,
    output logic              input_z_ack,
    output logic              busy,
    output logic              err_timeout
);

    localparam int unsigned STATE_W = 3;
    localparam int unsigned CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [STATE_W-1:0] IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] SEND_A = 3'd1;
    localparam logic [STATE_W-1:0] SEND_B = 3'd2;
    localparam logic [STATE_W-1:0] WAIT_Z = 3'd3;
    localparam logic [STATE_W-1:0] RESP   = 3'd4;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic               idle_q;
    logic               discard_q;
    logic               discard_d;
    logic [CNT_W-1:0]   wd_cnt_q;
    logic [CNT_W-1:0]   wd_cnt_d;
    logic               err_d;
    logic [TAG_W-1:0]   tag_q;
    logic               accept;
    logic               a_xfer;
    logic               b_xfer;
    logic               z_xfer;
    logic               wd_active;

    // idle_q is low during reset so req_ready only rises one cycle after release
    assign req_ready = idle_q && !flush;

    assign a_xfer = output_a_stb && output_a_ack;
    assign b_xfer = output_b_stb && output_b_ack;
    assign z_xfer = input_z_stb && input_z_ack;

    // State register
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, discard tracking and watchdog
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        discard_d = discard_q;
        wd_cnt_d  = wd_cnt_q;
        wd_active = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    accept    = 1'b1;
                    discard_d = 1'b0;
                    state_d   = SEND_A;
                end
            end
            SEND_A: begin
                wd_active = 1'b1;
                if (flush) discard_d = 1'b1;
                if (a_xfer) state_d = SEND_B;
            end
            SEND_B: begin
                wd_active = 1'b1;
                if (flush) discard_d = 1'b1;
                if (b_xfer) state_d = WAIT_Z;
            end
            WAIT_Z: begin
                wd_active = 1'b1;
                if (flush) discard_d = 1'b1;
                // The responder cannot be aborted: always finish Z, then drop it if flushed
                if (z_xfer) state_d = (discard_q || flush) ? IDLE : RESP;
            end
            RESP: begin
                // Flush wins over resp_ready: the pending response is withdrawn
                if (flush || resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (accept || (state_d != state_q)) begin
            wd_cnt_d = '0;
        end else if (wd_active && (wd_cnt_q != CNT_MAX)) begin
            wd_cnt_d = wd_cnt_q + CNT_W'(1);
        end

        err_d = err_timeout || ((TIMEOUT != 0) && (wd_cnt_d == CNT_MAX));
    end

    // Registered outputs, operand/result storage
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            idle_q       <= 1'b0;
            busy         <= 1'b0;
            output_a_stb <= 1'b0;
            output_b_stb <= 1'b0;
            input_z_ack  <= 1'b0;
            resp_valid   <= 1'b0;
            discard_q    <= 1'b0;
            wd_cnt_q     <= '0;
            err_timeout  <= 1'b0;
            output_a     <= '0;
            output_b     <= '0;
            tag_q        <= '0;
            resp_data    <= '0;
            resp_tag     <= '0;
        end else begin
            idle_q       <= (state_d == IDLE);
            busy         <= (state_d != IDLE);
            output_a_stb <= (state_d == SEND_A);
            output_b_stb <= (state_d == SEND_B);
            input_z_ack  <= (state_d == WAIT_Z);
            resp_valid   <= (state_d == RESP);
            discard_q    <= discard_d;
            wd_cnt_q     <= wd_cnt_d;
            err_timeout  <= err_d;
            if (accept) begin
                output_a <= req_a;
                output_b <= req_b;
                tag_q    <= req_tag;
            end
            if (z_xfer) begin
                resp_data <= input_z;
                resp_tag  <= tag_q;
            end
        end
    end

endmodule

// File: tb/tb_fp_hs_initiator.sv
// tb_fp_hs_initiator: directed and randomized checks of fp_hs_initiator against
// a behavioural FP-add responder and an expected-response queue.
module tb_fp_hs_initiator;

    logic        clk;
    logic        rst_l;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_tag;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [3:0]  resp_tag;
    logic        flush;
    logic [31:0] output_a;
    logic        output_a_stb;
    logic        output_a_ack;
    logic [31:0] output_b;
    logic        output_b_stb;
    logic        output_b_ack;
    logic [31:0] input_z;
    logic        input_z_stb;
    logic        input_z_ack;
    logic        busy;
    logic        err_timeout;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  tag;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int a_xfers = 0;
    int b_xfers = 0;
    int z_xfers = 0;
    int resp_count = 0;

    int a_delay = 0;
    int b_delay = 0;
    int z_delay = 0;
    bit b_never = 1'b0;
    logic [31:0] seen_a = '0;
    logic [31:0] seen_b = '0;

    fp_hs_initiator #(
        .TAG_W   (4),
        .TIMEOUT (8)
    ) dut (
        .clk          (clk),
        .rst_l        (rst_l),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_tag      (req_tag),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .resp_tag     (resp_tag),
        .flush        (flush),
        .output_a     (output_a),
        .output_a_stb (output_a_stb),
        .output_a_ack (output_a_ack),
        .output_b     (output_b),
        .output_b_stb (output_b_stb),
        .output_b_ack (output_b_ack),
        .input_z      (input_z),
        .input_z_stb  (input_z_stb),
        .input_z_ack  (input_z_ack),
        .busy         (busy),
        .err_timeout  (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Single-precision normal/zero -> real (denormals treated as zero)
    function automatic real sp_to_real(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) return 0.0;
        d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    // Real -> single precision; exact for values with at most 24 significant bits
    function automatic logic [31:0] real_to_sp(input real r);
        logic [63:0] d;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    // Responder: FP adder side of the three stb/ack channels
    initial begin : responder
        output_a_ack = 1'b0;
        output_b_ack = 1'b0;
        input_z_stb  = 1'b0;
        input_z      = '0;
        @(negedge clk);
        forever begin
            while (!output_a_stb) @(negedge clk);
            repeat (a_delay) @(negedge clk);
            output_a_ack = 1'b1;
            @(posedge clk);
            seen_a = output_a;
            @(negedge clk);
            output_a_ack = 1'b0;
            check("a_stb_drop", 64'(output_a_stb), 64'd0);

            while (!output_b_stb) @(negedge clk);
            while (b_never) @(negedge clk);
            repeat (b_delay) @(negedge clk);
            output_b_ack = 1'b1;
            @(posedge clk);
            seen_b = output_b;
            @(negedge clk);
            output_b_ack = 1'b0;
            check("b_stb_drop", 64'(output_b_stb), 64'd0);

            repeat (z_delay) @(negedge clk);
            input_z     = real_to_sp(sp_to_real(seen_a) + sp_to_real(seen_b));
            input_z_stb = 1'b1;
            do @(posedge clk); while (!input_z_ack);
            @(negedge clk);
            input_z_stb = 1'b0;
            check("z_ack_drop", 64'(input_z_ack), 64'd0);
        end
    end

    // Transfer counters and response scoreboard
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            if (rst_l) begin
                if (output_a_stb && output_a_ack) a_xfers++;
                if (output_b_stb && output_b_ack) b_xfers++;
                if (input_z_stb && input_z_ack) z_xfers++;
                if (resp_valid && resp_ready) begin
                    if (exp_q.size() == 0) begin
                        check("resp_unexpected", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("resp_data", 64'(resp_data), 64'(e.data));
                        check("resp_tag", 64'(resp_tag), 64'(e.tag));
                    end
                    resp_count++;
                end
            end
        end
    end

    initial begin : global_guard
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    task automatic send_req(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        int n;
        n = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("req_accept", 64'(n < 100), 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int target, input bit random_ready);
        int n;
        n = 0;
        while (resp_count < target && n < 300) begin
            @(negedge clk);
            if (random_ready) resp_ready = 1'($urandom_range(1));
            n++;
        end
        check("resp_arrived", 64'(resp_count >= target), 64'd1);
        @(negedge clk);
        resp_ready = 1'b1;
    endtask

    task automatic push_exp(input logic [31:0] d, input logic [3:0] t);
        exp_t e;
        e.data = d;
        e.tag  = t;
        exp_q.push_back(e);
    endtask

    initial begin : main
        int n;
        int a0;
        int b0;
        int z0;
        int ka;
        int kb;
        logic [3:0] t;

        rst_l      = 1'b0;
        req_valid  = 1'b0;
        req_a      = '0;
        req_b      = '0;
        req_tag    = '0;
        resp_ready = 1'b1;
        flush      = 1'b0;

        // Reset state
        #2;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_stbs", 64'({output_a_stb, output_b_stb, input_z_ack}), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_busy_err", 64'({busy, err_timeout}), 64'd0);
        repeat (2) @(negedge clk);
        rst_l = 1'b1;
        #1;
        check("release_req_ready_low", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        check("release_req_ready_high", 64'(req_ready), 64'd1);

        // 1.0 + 2.0, tag 3, minimum latency and single transfer per channel
        a0 = a_xfers; b0 = b_xfers; z0 = z_xfers;
        push_exp(32'h4040_0000, 4'd3);
        send_req(32'h3F80_0000, 32'h4000_0000, 4'd3);
        check("accept_a_stb", 64'(output_a_stb), 64'd1);
        check("accept_busy", 64'(busy), 64'd1);
        check("accept_req_ready", 64'(req_ready), 64'd0);
        n = 0;
        while (!resp_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("min_latency", 64'(n), 64'd3);
        wait_resp(1, 1'b0);
        check("seen_a", 64'(seen_a), 64'h3F80_0000);
        check("seen_b", 64'(seen_b), 64'h4000_0000);
        check("a_xfer_once", 64'(a_xfers - a0), 64'd1);
        check("b_xfer_once", 64'(b_xfers - b0), 64'd1);
        check("z_xfer_once", 64'(z_xfers - z0), 64'd1);

        // Back-to-back: 1.0+1.0 then -2.5+2.5
        push_exp(32'h4000_0000, 4'd5);
        push_exp(32'h0000_0000, 4'd6);
        send_req(32'h3F80_0000, 32'h3F80_0000, 4'd5);
        send_req(32'hC020_0000, 32'h4020_0000, 4'd6);
        wait_resp(3, 1'b0);

        // A ack delayed 5 cycles: A held 6 cycles, SEND_B on the ack edge
        a_delay = 5;
        push_exp(32'h40E0_0000, 4'd7);
        send_req(32'h4040_0000, 32'h4080_0000, 4'd7);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            check("a_held_stb", 64'(output_a_stb), 64'd1);
            check("a_held_data", 64'(output_a), 64'h4040_0000);
        end
        @(posedge clk);
        #1;
        check("a_done_stb", 64'(output_a_stb), 64'd0);
        check("send_b_entered", 64'(output_b_stb), 64'd1);
        a_delay = 0;
        wait_resp(4, 1'b0);

        // Flush during WAIT_Z: Z completes, no response, next request accepted
        z_delay = 3;
        z0 = z_xfers;
        send_req(32'h3F80_0000, 32'h3F80_0000, 4'd9);
        n = 0;
        while (!input_z_ack && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("wait_z_reached", 64'(input_z_ack), 64'd1);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n = 0;
        while (z_xfers == z0 && n < 50) begin
            @(posedge clk);
            #1;
            check("flush_no_resp_valid", 64'(resp_valid), 64'd0);
            n++;
        end
        check("flush_z_completed", 64'(z_xfers - z0), 64'd1);
        repeat (3) begin
            check("flush_no_resp_after", 64'(resp_valid), 64'd0);
            @(posedge clk);
            #1;
        end
        check("flush_idle", 64'(busy), 64'd0);
        z_delay = 0;
        push_exp(32'h40A0_0000, 4'd10);
        send_req(32'h4040_0000, 32'h4000_0000, 4'd10);
        wait_resp(5, 1'b0);

        // resp_ready held low for 10 cycles
        resp_ready = 1'b0;
        push_exp(32'h40E0_0000, 4'd11);
        send_req(32'h4040_0000, 32'h4080_0000, 4'd11);
        n = 0;
        while (!resp_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            check("stall_resp_valid", 64'(resp_valid), 64'd1);
            check("stall_resp_data", 64'(resp_data), 64'h40E0_0000);
            check("stall_req_ready", 64'(req_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        resp_ready = 1'b1;
        wait_resp(6, 1'b0);

        // Flush in RESP withdraws the response; data still held afterwards
        resp_ready = 1'b0;
        send_req(32'h40A0_0000, 32'h3F80_0000, 4'd12);
        n = 0;
        while (!resp_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("resp_flush_pre", 64'(resp_valid), 64'd1);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        check("resp_flush_valid", 64'(resp_valid), 64'd0);
        check("resp_flush_busy", 64'(busy), 64'd0);
        check("resp_flush_hold", 64'(resp_data), 64'h40C0_0000);
        @(negedge clk);
        flush = 1'b0;
        resp_ready = 1'b1;

        // Randomized operations with random responder delays and back-pressure
        for (int i = 0; i < 16; i++) begin
            ka = int'($urandom_range(4000)) - 2000;
            kb = int'($urandom_range(4000)) - 2000;
            t  = 4'($urandom_range(15));
            a_delay = int'($urandom_range(4));
            b_delay = int'($urandom_range(4));
            z_delay = int'($urandom_range(4));
            push_exp(real_to_sp(real'(ka + kb)), t);
            send_req(real_to_sp(real'(ka)), real_to_sp(real'(kb)), t);
            wait_resp(7 + i, 1'b1);
        end
        a_delay = 0;
        b_delay = 0;
        z_delay = 0;
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        // Watchdog: B never acknowledged, TIMEOUT = 8
        b_never = 1'b1;
        send_req(32'h3F80_0000, 32'h3F80_0000, 4'd1);
        n = 0;
        while (!output_b_stb && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("wd_send_b", 64'(output_b_stb), 64'd1);
        check("wd_err_initial", 64'(err_timeout), 64'd0);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            check("wd_err", 64'(err_timeout), 64'(k == 8));
        end
        repeat (4) @(posedge clk);
        #1;
        check("wd_err_sticky", 64'(err_timeout), 64'd1);
        check("wd_still_waiting", 64'(output_b_stb), 64'd1);

        // Asynchronous reset mid-operation
        #2;
        rst_l = 1'b0;
        #1;
        check("arst_stbs", 64'({output_a_stb, output_b_stb, input_z_ack}), 64'd0);
        check("arst_flags", 64'({resp_valid, busy, err_timeout, req_ready}), 64'd0);
        check("arst_data", 64'({output_a, output_b}), 64'd0);
        check("arst_resp", 64'({resp_data, resp_tag}), 64'd0);
        @(negedge clk);
        rst_l = 1'b1;
        @(posedge clk);
        #1;
        check("arst_release_ready", 64'(req_ready), 64'd1);
        check("arst_release_busy", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
